// File: rtl/fp_mult_arb_pkg.sv
// fp_mult_arb_pkg: shared types, multiplier latency and operand-slice helpers for fp_mult_arbiter
package fp_mult_arb_pkg;
  localparam int FP_MULT_LAT = 3;
  localparam int MAX_REQ = 8;
  typedef struct packed {
    logic huge;
    logic tiny;
    logic nan;
    logic inf;
    logic zero;
  } fp_status_t;
  typedef enum logic [2:0] {
    RND_NE = 3'd0,
    RND_TZ = 3'd1,
    RND_DN = 3'd2,
    RND_UP = 3'd3,
    RND_MM = 3'd4
  } fp_rnd_t;
  function automatic logic [31:0] req_slice32(input logic [MAX_REQ*32-1:0] v, input int i);
    return v[32*i +: 32];
  endfunction
  function automatic logic [2:0] req_slice3(input logic [MAX_REQ*3-1:0] v, input int i);
    return v[3*i +: 3];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr
// Ports: req (requests), en (grant enable), ptr (search start), grant (one-hot), idx (granted index)
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);
  logic [PW:0] s;
  logic [PW-1:0] j;
  logic hit;
  always_comb begin
    grant = '0;
    idx = '0;
    hit = 1'b0;
    s = '0;
    j = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, ptr} + (PW+1)'(i);
      // explicit wrap so non-power-of-two NREQ never indexes past the last requester
      j = PW'(s >= (PW+1)'(NREQ) ? s - (PW+1)'(NREQ) : s);
      if (en && !hit && req[j]) begin
        grant[j] = 1'b1;
        idx = j;
        hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one pipelined fp multiplier among NREQ requesters
// Ports: req_* (requester side, valid/ready), mul_* (registered multiplier operands, result/status in),
//        rsp_* (one-hot result strobe with shared result/status bus), busy (work in flight).
// Optional: define FP_MULT_ARB_STICKY_EN to add per-requester sticky status (sticky_clr/sticky_status).
module fp_mult_arbiter
  import fp_mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT = FP_MULT_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_rnd,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  output logic [2:0]        mul_rnd,
  input  logic [31:0]       mul_z,
  input  logic [4:0]        mul_status,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_z,
  output logic [4:0]        rsp_status,
  output logic              busy
`ifdef FP_MULT_ARB_STICKY_EN
  ,
  input  logic [NREQ-1:0]   sticky_clr,
  output logic [NREQ*5-1:0] sticky_status
`endif
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, gidx;
  logic [NREQ-1:0] grant;
  logic [LAT:0] tag_v;
  logic [PW-1:0] tag_id [LAT+1];
  logic grant_any;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .en(en),
    .ptr(ptr),
    .grant(grant),
    .idx(gidx)
  );
  assign req_ready = grant;
  assign grant_any = |grant;
  assign busy = |tag_v || |rsp_valid;
  // stage 0 tracks the operand register, stages 1..LAT track the multiplier pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      tag_v <= '0;
      for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_rnd <= '0;
      rsp_valid <= '0;
      rsp_z <= '0;
      rsp_status <= '0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], grant_any};
      tag_id[0] <= gidx;
      for (int i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
      rsp_valid <= '0;
      if (grant_any) begin
        mul_a <= req_slice32((MAX_REQ*32)'(req_a), int'(gidx));
        mul_b <= req_slice32((MAX_REQ*32)'(req_b), int'(gidx));
        mul_rnd <= req_slice3((MAX_REQ*3)'(req_rnd), int'(gidx));
        ptr <= gidx == PW'(NREQ-1) ? '0 : gidx + 1'b1;
      end
      if (tag_v[LAT]) begin
        rsp_valid[tag_id[LAT]] <= 1'b1;
        rsp_z <= mul_z;
        rsp_status <= mul_status;
      end
    end
  end
`ifdef FP_MULT_ARB_STICKY_EN
  fp_status_t sticky [NREQ];
  // a clear coinciding with a new result keeps the new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) sticky[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (tag_v[LAT] && tag_id[LAT] == PW'(i))
          sticky[i] <= fp_status_t'(sticky_clr[i] ? mul_status : sticky[i] | mul_status);
        else if (sticky_clr[i])
          sticky[i] <= '0;
    end
  end
  for (genvar g = 0; g < NREQ; g++) begin : g_sticky
    assign sticky_status[5*g +: 5] = sticky[g];
  end
`endif
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: scoreboard bench for fp_mult_arbiter with a behavioural 3-stage multiplier
module tb_fp_mult_arbiter;
  localparam int NREQ = 4;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_a = '0, req_b = '0;
  logic [NREQ*3-1:0] req_rnd = '0;
  logic [31:0] mul_a, mul_b, mul_z, rsp_z;
  logic [2:0] mul_rnd;
  logic [4:0] mul_status, rsp_status;
  logic busy;
`ifdef FP_MULT_ARB_STICKY_EN
  logic [NREQ-1:0] sticky_clr = '0;
  logic [NREQ*5-1:0] sticky_status;
`endif
  int tests = 0, fails = 0, cyc = 0, rsp_seen = 0;
  typedef struct {
    int id;
    logic [31:0] z;
    logic [4:0] st;
    int due;
  } exp_t;
  exp_t sb[$];
  int gq[$];
  logic [36:0] mpipe [LAT];

  fp_mult_arbiter #(.NREQ(NREQ), .LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
    .mul_z(mul_z), .mul_status(mul_status),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_status(rsp_status),
    .busy(busy)
`ifdef FP_MULT_ARB_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky_status(sticky_status)
`endif
  );

  always #5 clk = ~clk;

  // reference multiplier: truncating, denormals as zero; overflow/underflow only raise huge/tiny
  function automatic logic [36:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s, na, nb, ia, ib, za, zb;
    logic [47:0] p;
    logic [22:0] m;
    int e;
    s = a[31] ^ b[31];
    na = a[30:23] == 8'hFF && a[22:0] != 0;
    nb = b[30:23] == 8'hFF && b[22:0] != 0;
    ia = a[30:23] == 8'hFF && a[22:0] == 0;
    ib = b[30:23] == 8'hFF && b[22:0] == 0;
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    if (na || nb || (ia && zb) || (ib && za)) return {5'b00100, 32'h7FC00000};
    if (ia || ib) return {5'b00010, s, 8'hFF, 23'h0};
    if (za || zb) return {5'b00001, s, 31'h0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m = p[46:24];
    end else m = p[45:23];
    if (e >= 255) return {5'b10000, s, 8'hFF, 23'h0};
    if (e <= 0) return {5'b01000, s, 31'h0};
    return {5'b00000, s, e[7:0], m};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_z = mpipe[LAT-1][31:0];
  assign mul_status = mpipe[LAT-1][36:32];

  always @(negedge clk) begin
    exp_t e;
    logic [36:0] r;
    logic [NREQ-1:0] oh;
    if (rst_n) begin
      tests++;
      if ((req_ready & ~req_valid) != 0 || !$onehot0(req_ready)) begin
        fails++;
        $display("FAIL grant_legal: ready=%b valid=%b", req_ready, req_valid);
      end
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin
          r = fmul(req_a[32*i +: 32], req_b[32*i +: 32]);
          sb.push_back('{i, r[31:0], r[36:32], cyc + LAT + 2});
          gq.push_back(i);
        end
      if (|rsp_valid) begin
        rsp_seen++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: rsp_valid=%b z=%h", rsp_valid, rsp_z);
        end else begin
          e = sb.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          if (rsp_valid !== oh || rsp_z !== e.z || rsp_status !== e.st || cyc != e.due) begin
            fails++;
            $display("FAIL rsp_match: got v=%b z=%h st=%b cyc=%0d, want v=%b z=%h st=%b cyc=%0d",
                     rsp_valid, rsp_z, rsp_status, cyc, oh, e.z, e.st, e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_rnd[3*i +: 3] = r;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    sb.delete();
    gq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_rsp(input string nm, output int n);
    n = 0;
    while (!(|rsp_valid) && n < 12) begin
      tick();
      n++;
    end
    if (!(|rsp_valid)) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no rsp_valid within %0d cycles", nm, n);
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    tick();
    tick();
    tests++;
    if ({rsp_valid, rsp_z, rsp_status, busy} !== '0) begin
      fails++;
      $display("FAIL reset_rsp: v=%b z=%h st=%b busy=%b, want all 0", rsp_valid, rsp_z, rsp_status, busy);
    end
    tests++;
    if ({mul_a, mul_b, mul_rnd} !== '0) begin
      fails++;
      $display("FAIL reset_mul: a=%h b=%h rnd=%h, want 0", mul_a, mul_b, mul_rnd);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    set_req(2, 32'h40000000, 32'h40400000, 3'd1);
    req_valid = 4'b0100;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tests++;
    if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000 || mul_rnd !== 3'd1) begin
      fails++;
      $display("FAIL single_mul_regs: a=%h b=%h rnd=%h", mul_a, mul_b, mul_rnd);
    end
    wait_rsp("single", n);
    tests++;
    if (n != 4 || rsp_valid !== 4'b0100 || rsp_z !== 32'h40C00000 || rsp_status !== 5'b0) begin
      fails++;
      $display("FAIL single_rsp: wait=%0d v=%b z=%h st=%b, want 4 0100 40c00000 0", n, rsp_valid, rsp_z, rsp_status);
    end
    tick();
    tests++;
    if (rsp_valid !== '0 || rsp_z !== 32'h40C00000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_hold: v=%b z=%h busy=%b", rsp_valid, rsp_z, busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)},
                   {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)}, 3'(i));
      req_valid = 4'b1111;
      tick();
    end
    req_valid = '0;
    tests++;
    if (gq.size() != 8) begin
      fails++;
      $display("FAIL rr_count: got %0d grants want 8", gq.size());
    end else
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (gq[k] != k % NREQ) begin
          fails++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", k, gq[k], k % NREQ);
        end
      end
    repeat (8) tick();
    tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rr_drain: pending=%0d busy=%b, want 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_special();
    int n;
    set_req(1, 32'h7F800000, 32'h00000000, 3'd0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_rsp("nan", n);
    tests++;
    if (rsp_valid !== 4'b0010 || rsp_status[2] !== 1'b1 || rsp_z[30:23] !== 8'hFF) begin
      fails++;
      $display("FAIL special_nan: v=%b st=%b z=%h", rsp_valid, rsp_status, rsp_z);
    end
    tick();
    set_req(3, 32'h00000000, 32'h3F800000, 3'd2);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    wait_rsp("zero", n);
    tests++;
    if (rsp_valid !== 4'b1000 || rsp_status !== 5'b00001) begin
      fails++;
      $display("FAIL special_zero: v=%b st=%b, want 1000 00001", rsp_valid, rsp_status);
    end
    tick();
  endtask

  task automatic test_enable();
    en = 1'b0;
    set_req(0, 32'h3FC00000, 32'h40000000, 3'd0);
    req_valid = 4'b0001;
    repeat (3) begin
      #1;
      tests++;
      if (req_ready !== '0) begin
        fails++;
        $display("FAIL en_block: ready=%b want 0000", req_ready);
      end
      tick();
    end
    en = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL en_grant: ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL en_busy[%0d]: busy=%b want 1", k, busy);
      end
      tick();
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL en_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int i = 0; i < 3; i++) set_req(i, 32'h3F800000 + (i << 20), 32'h40000000, 3'd0);
    req_valid = 4'b0111;
    repeat (3) tick();
    req_valid = '0;
    rst_n = 1'b0;
    sb.delete();
    seen = rsp_seen;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_busy: busy=%b want 0", busy);
    end
    repeat (10) tick();
    tests++;
    if (rsp_seen != seen) begin
      fails++;
      $display("FAIL rstmid_rsp: %0d responses after reset, want 0", rsp_seen - seen);
    end
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_ptr: ready=%b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (8) tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 3; c++) begin
      set_req(2, {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)}, 32'h3FA00000, 3'(c));
      req_valid = 4'b0100;
      #1;
      tests++;
      if (req_ready !== 4'b0100) begin
        fails++;
        $display("FAIL b2b_ready[%0d]: ready=%b want 0100", c, req_ready);
      end
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
  endtask

`ifdef FP_MULT_ARB_STICKY_EN
  task automatic test_sticky();
    do_reset();
    tests++;
    if (sticky_status !== '0) begin
      fails++;
      $display("FAIL sticky_reset: %h want 0", sticky_status);
    end
    set_req(0, 32'h7F000000, 32'h7F000000, 3'd0);
    req_valid = 4'b0001;
    tick();
    set_req(0, 32'h00800000, 32'h00800000, 3'd0);
    tick();
    req_valid = '0;
    repeat (7) tick();
    tests++;
    if (sticky_status !== 20'h00018) begin
      fails++;
      $display("FAIL sticky_accum: %h want 00018", sticky_status);
    end
    set_req(0, 32'h00000000, 32'h3F800000, 3'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (3) tick();
    sticky_clr = 4'b0001;
    tick();
    sticky_clr = '0;
    tests++;
    if (rsp_valid !== 4'b0001 || sticky_status !== 20'h00001) begin
      fails++;
      $display("FAIL sticky_clr_set: v=%b sticky=%h want 0001 00001", rsp_valid, sticky_status);
    end
    repeat (3) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_special();
    test_enable();
    test_reset_mid();
    test_back_to_back();
`ifdef FP_MULT_ARB_STICKY_EN
    test_sticky();
`endif
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL final_drain: %0d responses never arrived", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
Shares one pipelined fp_mult instance (LAT-cycle latency, status flags zero/inf/nan/tiny/huge) among NREQ requesters. Round-robin arbitration issues at most one operation per cycle. A tag pipeline tracks which requester owns each in-flight operation. Each result and its status are routed back to the owning requester. The block sits between the multiplier and its client units in the FP cluster.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, multiplier latency in cycles from mul_a/mul_b sampled to mul_z/mul_status valid.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous assert, active-low.
- en  in  1  issue enable; 0 blocks new grants, in-flight operations still complete.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready.
- req_a  in  NREQ*32  operand a per requester, slice i = [32i+31:32i].
- req_b  in  NREQ*32  operand b per requester.
- req_rnd  in  NREQ*3  rounding mode per requester.
- mul_a  out  32  operand a to the multiplier.
- mul_b  out  32  operand b to the multiplier.
- mul_rnd  out  3  rounding mode to the multiplier.
- mul_z  in  32  multiplier result.
- mul_status  in  5  {huge,tiny,nan,inf,zero} from the multiplier.
- rsp_valid  out  NREQ  one-hot, single-cycle result strobe to the owning requester.
- rsp_z  out  32  result, shared bus.
- rsp_status  out  5  status, shared bus.
- busy  out  1  1 while any operation is in flight or a response is pending.
- sticky_clr  in  NREQ  (only with STICKY_EN) clears the requester's sticky flags.
- sticky_status  out  NREQ*5  (only with STICKY_EN) per-requester accumulated flags.

Behaviour:
- Reset:
  - rr pointer=0; tag pipe cleared; rsp_valid=0; rsp_z=0; rsp_status=0; busy=0; sticky=0.
  - mul_a, mul_b and mul_rnd are registered and reset to 0.
- Arbitration (combinational):
  - Search req_valid starting at pointer, wrapping modulo NREQ. The first valid index k gets req_ready[k]=1, only if en=1.
  - req_ready is never asserted without the matching req_valid.
  - Zero or one bit of req_ready is set per cycle.
- Grant cycle t:
  - Register req_a[k], req_b[k] and req_rnd[k] into mul_a, mul_b and mul_rnd. The multiplier samples them at t+1.
  - Push {1,k} into the tag pipe. Pointer becomes (k+1) mod NREQ.
  - With no grant: mul_* hold their values, push {0,x}, pointer unchanged.
- Tag pipe:
  - LAT+1 stages: one for the operand register, LAT for the multiplier.
  - When the tail entry is valid, register mul_z and mul_status into rsp_z and rsp_status, and set rsp_valid[id]=1 for one cycle.
  - Total request-to-response latency is LAT+2 cycles from the grant edge.
- Responses have no backpressure; the requester must accept. rsp_z and rsp_status hold their last values while rsp_valid=0.
- Throughput: one operation per cycle sustained. The same requester may be granted again next cycle only if no other requester is valid.
- busy = OR of all tag valid bits OR any rsp_valid.
- en toggling: en=0 only masks new grants; tag pipe and pointer keep their state.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is produced for results that emerge after reset release.
- NREQ not a power of two: pointer wrap uses an explicit compare, not bit truncation.

Optional Feature:
- Macro FP_MULT_ARB_STICKY_EN.
- Defined:
  - Per-requester 5-bit sticky register, ORed with mul_status whenever that requester's rsp_valid is set.
  - sticky_clr[i] clears register i. If clear and set occur in the same cycle, set wins.
  - sticky_status and sticky_clr ports exist.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package fp_mult_arb_pkg:
  - typedef fp_status_t, a packed struct {huge,tiny,nan,inf,zero}.
  - rounding-mode enum (3-bit).
  - FP_MULT_LAT=3 constant.
  - helper functions req_slice32 and req_slice3.
- Sub-module rr_arbiter:
  - Parameter NREQ; inputs req, en, pointer; outputs one-hot grant and index.
  - Reused elsewhere in the codebase.

Test Plan:
- Single op: requester 2 issues a=0x40000000, b=0x40400000 -> 5 cycles later rsp_valid=4'b0100, rsp_z=0x40C00000, rsp_status=0.
- All four requesters valid for 8 cycles, en=1 -> grant order 0,1,2,3,0,1,2,3. Responses come back in the same order on consecutive cycles.
- Requester 1 issues a=0x7F800000, b=0x00000000 -> rsp_valid[1]=1, nan flag=1, rsp_z exponent 0xFF. Next, requester 3 issues 0x00000000*0x3F800000 -> zero flag, rsp_valid[3]=1.
- Requester 0 valid with en=0 for 3 cycles -> req_ready=0 throughout. Raising en grants on that cycle; busy is high for the next 5 cycles.
- Issue 3 ops, assert rst after 2 cycles -> no rsp_valid ever pulses for those ops, busy=0 and pointer=0 after release.
- (STICKY_EN) requester 0 gets huge then tiny results -> sticky_status[4:0]=5'b11000. sticky_clr[0] with a simultaneous zero response -> 5'b00001.
